acc_operand_loader: RTL and testbench
=====================================

Name: acc_operand_loader

Overview:
- Upstream stage of the accelerator matrix multiplier.
- Accepts a stream of 32-bit words, unpacks them into the operand matrices A and B, then holds both matrices stable on its outputs.
- Issues a one-cycle start pulse to the multiplier and waits for its done before accepting the next operand set.
- Word source is the SoC-side bus adapter (valid/ready stream).

Parameters:
- dat_size, 8, element width in bits; must divide 32 (legal: 8, 16, 32).
- mat_size, 2, matrix dimension; each matrix holds N = mat_size*mat_size elements.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; returns block to LOAD_A.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  32  packed operand word.
- start  output  1  one-cycle start pulse to multiplier.
- done  input  1  multiplier finished (single-cycle pulse or level; first high cycle counts).
- busy  output  1  high in START and WAIT_DONE.
- mat_A  output  [N-1:0][dat_size-1:0]  operand A, element k = row*mat_size+col.
- mat_B  output  [N-1:0][dat_size-1:0]  operand B, same indexing.

Behaviour:
- Derived constants: EPW = 32/dat_size elements per word; W = ceil(N/EPW) words per matrix.
- Reset (rst_n low, async): state = LOAD_A; word counter = 0; mat_A = 0; mat_B = 0; start = 0; busy = 0; in_ready = 1 after reset release.
- Transfer: a word is accepted iff in_valid && in_ready at a rising clk edge.
- Unpacking: word w carries elements k = w*EPW+j for j = 0..EPW-1, taken from in_data[j*dat_size +: dat_size] (element 0 in LSBs).
- Partial last word: elements with k >= N are discarded.
- State LOAD_A:
  - in_ready = 1; each accepted word is written into mat_A; counter increments.
  - On accept of word W-1: counter -> 0, go to LOAD_B.
- State LOAD_B:
  - Same as LOAD_A, writing mat_B.
  - On accept of word W-1: go to START.
- State START (one cycle):
  - start = 1 (registered, so the pulse appears the cycle after the last B word is accepted); in_ready = 0; go to WAIT_DONE.
- State WAIT_DONE:
  - in_ready = 0; start = 0.
  - On done = 1: go to LOAD_A with counter = 0; in_ready = 1 in the following cycle.
- Stability: mat_A and mat_B change only on accepted words; they are constant from START until the next accepted word, covering the whole multiplication.
- done outside WAIT_DONE: ignored.
- done in the same cycle START is asserted: ignored; the block enters WAIT_DONE and waits for a later done.
- clear (priority over all other events except rst_n):
  - Next state = LOAD_A; counter = 0; start = 0; mat_A/mat_B are not modified.
  - A word presented in the same cycle as clear is not accepted; in_ready is forced 0 that cycle.
- clear or rst_n during WAIT_DONE: operation abandoned; the late done from the multiplier is ignored because the block is no longer in WAIT_DONE.
- No internal buffering beyond the matrices: back-pressure via in_ready is the only flow control.
- Latency:
  - Last B word accepted at edge t; start high during cycle t+1.
  - Minimum load time is 2W cycles at full throughput.

Test Plan:
- Basic load, defaults: send 0x04030201 then 0x08070605 -> mat_A = {04,03,02,01}, mat_B = {08,07,06,05} (index 3..0); start high exactly one cycle after the 2nd accept; busy = 1.
- Partial word, mat_size=3, dat_size=8 (W=3): A words 0x04030201, 0x08070605, 0xAABBCC09 -> mat_A[8] = 0x09, 0xCC/0xBB/0xAA dropped; B loads identically; one start pulse.
- Back-pressure: hold in_valid=1 with a third word during WAIT_DONE for 10 cycles -> in_ready = 0, operands unchanged; assert done -> word accepted into mat_A[0..3] next cycle.
- Spurious done: pulse done during LOAD_A and in the START cycle -> no state change; block stays waiting until a later done.
- Clear mid-load: after the A word, assert clear with in_valid=1 -> word not accepted; next word reloads mat_A (not mat_B); no start pulse.
- Async reset: drop rst_n mid-cycle in WAIT_DONE -> outputs zero immediately without a clk edge; after release, in_ready = 1 and a subsequent done is ignored.

Source files
------------

// File: rtl/acc_operand_loader_if.sv
// Word stream from the SoC-side bus adapter into the operand loader.
// The loader sits on the slave side and applies back-pressure through in_ready.
interface acc_operand_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/acc_operand_loader.sv
// Operand loader for the matrix multiplier.
// Unpacks a stream of 32-bit words into matrices A and B (element 0 in the
// LSBs of each word), fires a one-cycle start pulse and then holds both
// matrices stable until the multiplier reports done.
module acc_operand_loader #(
  parameter int dat_size = 8,
  parameter int mat_size = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         clear,
  acc_operand_loader_if.slave                          bus,
  output logic                                         start,
  input  logic                                         done,
  output logic                                         busy,
  output logic [mat_size*mat_size-1:0][dat_size-1:0]   mat_A,
  output logic [mat_size*mat_size-1:0][dat_size-1:0]   mat_B
);

  localparam int N   = mat_size * mat_size;
  localparam int EPW = 32 / dat_size;
  localparam int W   = (N + EPW - 1) / EPW;
  localparam int CW  = (W > 1) ? $clog2(W) : 1;

  localparam logic [CW-1:0] LAST_WORD = CW'(W - 1);

  typedef enum logic [1:0] {
    LOAD_A    = 2'd0,
    LOAD_B    = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] next_cnt;
  logic          loading;
  logic          accept;
  logic          last_word;

  // Words are only taken while loading, and never in a cycle that is being aborted.
  always_comb begin
    loading      = (state == LOAD_A) || (state == LOAD_B);
    bus.in_ready = loading && !clear;
    accept       = bus.in_valid && bus.in_ready;
    last_word    = (word_cnt == LAST_WORD);
  end

  // State register and word counter; reset puts the block back at the start of A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD_A;
      word_cnt <= '0;
    end else begin
      state    <= next_state;
      word_cnt <= next_cnt;
    end
  end

  // Next-state logic; clear overrides everything, done only matters while waiting.
  always_comb begin
    next_state = state;
    next_cnt   = word_cnt;
    if (clear) begin
      next_state = LOAD_A;
      next_cnt   = '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (accept) begin
            if (last_word) begin
              next_cnt   = '0;
              next_state = LOAD_B;
            end else begin
              next_cnt = word_cnt + CW'(1);
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (last_word) begin
              next_cnt   = '0;
              next_state = START;
            end else begin
              next_cnt = word_cnt + CW'(1);
            end
          end
        end
        START: begin
          next_state = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done) begin
            next_state = LOAD_A;
            next_cnt   = '0;
          end
        end
        default: begin
          next_state = LOAD_A;
          next_cnt   = '0;
        end
      endcase
    end
  end

  // Registered status outputs so start is a clean single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start <= 1'b0;
      busy  <= 1'b0;
    end else begin
      start <= (next_state == START);
      busy  <= (next_state == START) || (next_state == WAIT_DONE);
    end
  end

  // Each element has a fixed home word and slot; slots past the last element are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_A <= '0;
      mat_B <= '0;
    end else if (accept) begin
      for (int k = 0; k < N; k++) begin
        if (word_cnt == CW'(k / EPW)) begin
          if (state == LOAD_A) begin
            mat_A[k] <= bus.in_data[(k % EPW)*dat_size +: dat_size];
          end else begin
            mat_B[k] <= bus.in_data[(k % EPW)*dat_size +: dat_size];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_operand_loader.sv
// Testbench for acc_operand_loader: a 2x2 instance driven from a vector table
// and hand-written sequences, and a 3x3 instance (partial last word) driven
// with random traffic against a word-counting reference model.
module tb_acc_operand_loader;

  logic clk;
  logic rst_n;

  // 2x2, 8-bit instance: one word per matrix
  logic             clear1;
  logic             done1;
  logic             start1;
  logic             busy1;
  logic [3:0][7:0]  mat_a1;
  logic [3:0][7:0]  mat_b1;
  acc_operand_loader_if bus1 ();

  // 3x3, 8-bit instance: three words per matrix, last one partial
  logic             clear3;
  logic             done3;
  logic             start3;
  logic             busy3;
  logic [8:0][7:0]  mat_a3;
  logic [8:0][7:0]  mat_b3;
  acc_operand_loader_if bus3 ();

  int compared = 0;
  int mismatched = 0;

  acc_operand_loader #(.dat_size(8), .mat_size(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear1),
    .bus   (bus1),
    .start (start1),
    .done  (done1),
    .busy  (busy1),
    .mat_A (mat_a1),
    .mat_B (mat_b1)
  );

  acc_operand_loader #(.dat_size(8), .mat_size(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear3),
    .bus   (bus3),
    .start (start3),
    .done  (done3),
    .busy  (busy3),
    .mat_A (mat_a3),
    .mat_B (mat_b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        done;
    logic        clear;
    logic        exp_ready;
    logic        exp_start;
    logic        exp_busy;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [31:0] d, logic dn, logic c,
                              logic r, logic s, logic b,
                              logic [31:0] a, logic [31:0] bb);
    vec_t t;
    t.valid = v; t.data = d; t.done = dn; t.clear = c;
    t.exp_ready = r; t.exp_start = s; t.exp_busy = b;
    t.exp_a = a; t.exp_b = bb;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] d,
                                input logic dn, input logic c);
    @(negedge clk);
    bus1.in_valid = v;
    bus1.in_data  = d;
    done1         = dn;
    clear1        = c;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // reference model state for the 3x3 instance
  int         m_words;
  bit         m_loading;
  bit         m_pulse;
  bit         m_waiting;
  logic [7:0] m_a[9];
  logic [7:0] m_b[9];

  initial begin
    logic [71:0] exp_a3;
    logic [71:0] exp_b3;
    logic [31:0] words3[6];
    int          pulses;
    logic        v;
    logic [31:0] d;
    logic        dn;
    logic        c;

    rst_n = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; done1 = 1'b0; clear1 = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_data = '0; done3 = 1'b0; clear3 = 1'b0;
    apply_reset();

    // ---- table-driven sequence on the 2x2 instance ----
    vecs.push_back(mk(1, 32'h04030201, 0, 0, 1, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 32'h08070605, 0, 0, 1, 0, 0, 32'h04030201, 32'h0));
    vecs.push_back(mk(1, 32'h0C0B0A09, 1, 0, 0, 1, 1, 32'h04030201, 32'h08070605));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, 32'h0C0B0A09, 0, 0, 0, 0, 1, 32'h04030201, 32'h08070605));
    vecs.push_back(mk(1, 32'h0C0B0A09, 1, 0, 0, 0, 1, 32'h04030201, 32'h08070605));
    vecs.push_back(mk(1, 32'h0C0B0A09, 0, 0, 1, 0, 0, 32'h04030201, 32'h08070605));
    vecs.push_back(mk(1, 32'h11111111, 1, 1, 0, 0, 0, 32'h0C0B0A09, 32'h08070605));
    vecs.push_back(mk(1, 32'h22222222, 1, 0, 1, 0, 0, 32'h0C0B0A09, 32'h08070605));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1, 0, 0, 32'h22222222, 32'h08070605));
    vecs.push_back(mk(1, 32'h33333333, 0, 1, 0, 0, 0, 32'h22222222, 32'h08070605));
    vecs.push_back(mk(1, 32'h44444444, 0, 0, 1, 0, 0, 32'h22222222, 32'h08070605));
    vecs.push_back(mk(1, 32'h55555555, 0, 0, 1, 0, 0, 32'h44444444, 32'h08070605));
    vecs.push_back(mk(0, 32'h0,        0, 1, 0, 1, 1, 32'h44444444, 32'h55555555));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1, 0, 0, 32'h44444444, 32'h55555555));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].valid, vecs[i].data, vecs[i].done, vecs[i].clear);
      #1;
      check_output($sformatf("vec%0d_ready", i), 128'(bus1.in_ready), 128'(vecs[i].exp_ready));
      check_output($sformatf("vec%0d_start", i), 128'(start1), 128'(vecs[i].exp_start));
      check_output($sformatf("vec%0d_busy", i),  128'(busy1),  128'(vecs[i].exp_busy));
      check_output($sformatf("vec%0d_mat_A", i), 128'(mat_a1), 128'(vecs[i].exp_a));
      check_output($sformatf("vec%0d_mat_B", i), 128'(mat_b1), 128'(vecs[i].exp_b));
    end
    apply_stimulus(0, 32'h0, 0, 0);

    // ---- partial last word on the 3x3 instance ----
    words3[0] = 32'h04030201; words3[1] = 32'h08070605; words3[2] = 32'hAABBCC09;
    words3[3] = 32'h04030201; words3[4] = 32'h08070605; words3[5] = 32'hAABBCC09;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus3.in_valid = 1'b1;
      bus3.in_data  = words3[i];
      #1;
      check_output($sformatf("partial_ready%0d", i), 128'(bus3.in_ready), 128'(1));
    end
    @(negedge clk);
    bus3.in_valid = 1'b0;
    #1;
    check_output("partial_start_latency", 128'(start3), 128'(1));
    check_output("partial_busy", 128'(busy3), 128'(1));
    check_output("partial_mat_A", 128'(mat_a3), 128'(72'h090807060504030201));
    check_output("partial_mat_B", 128'(mat_b3), 128'(72'h090807060504030201));
    pulses = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (start3) pulses++;
    end
    check_output("partial_pulse_count", 128'(pulses), 128'(1));
    @(negedge clk); done3 = 1'b1;
    @(negedge clk); done3 = 1'b0;
    #1;
    check_output("partial_ready_after_done", 128'(bus3.in_ready), 128'(1));
    check_output("partial_busy_after_done", 128'(busy3), 128'(0));

    // ---- random traffic on the 3x3 instance against the reference model ----
    apply_reset();
    m_words = 0; m_loading = 1; m_pulse = 0; m_waiting = 0;
    for (int k = 0; k < 9; k++) begin m_a[k] = '0; m_b[k] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      v  = ($urandom_range(0, 3) != 0);
      d  = $urandom;
      dn = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      bus3.in_valid = v; bus3.in_data = d; done3 = dn; clear3 = c;
      #1;
      for (int k = 0; k < 9; k++) begin
        exp_a3[k*8 +: 8] = m_a[k];
        exp_b3[k*8 +: 8] = m_b[k];
      end
      check_output($sformatf("rand%0d_ready", cyc), 128'(bus3.in_ready), 128'(m_loading && !c));
      check_output($sformatf("rand%0d_start", cyc), 128'(start3), 128'(m_pulse));
      check_output($sformatf("rand%0d_busy", cyc),  128'(busy3),  128'(m_pulse || m_waiting));
      check_output($sformatf("rand%0d_mat_A", cyc), 128'(mat_a3), 128'(exp_a3));
      check_output($sformatf("rand%0d_mat_B", cyc), 128'(mat_b3), 128'(exp_b3));
      // words 0..2 of a set go to A, 3..5 to B; word w holds elements 4w..4w+3
      if (c) begin
        m_loading = 1; m_words = 0; m_pulse = 0; m_waiting = 0;
      end else if (m_loading) begin
        if (v) begin
          for (int j = 0; j < 4; j++) begin
            int idx;
            idx = (m_words % 3) * 4 + j;
            if (idx < 9) begin
              if (m_words < 3) m_a[idx] = d[j*8 +: 8];
              else             m_b[idx] = d[j*8 +: 8];
            end
          end
          m_words++;
          if (m_words == 6) begin
            m_words = 0; m_loading = 0; m_pulse = 1;
          end
        end
      end else if (m_pulse) begin
        m_pulse = 0; m_waiting = 1;
      end else if (m_waiting && dn) begin
        m_waiting = 0; m_loading = 1;
      end
    end
    @(negedge clk);
    bus3.in_valid = 1'b0; done3 = 1'b0; clear3 = 1'b0;

    // ---- asynchronous reset while waiting for done on the 2x2 instance ----
    apply_stimulus(1, 32'hDEADBEEF, 0, 0);
    apply_stimulus(1, 32'h12345678, 0, 0);
    apply_stimulus(0, 32'h0, 0, 0);
    #1;
    check_output("areset_start_pulse", 128'(start1), 128'(1));
    check_output("areset_loaded_A", 128'(mat_a1), 128'(32'hDEADBEEF));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("areset_mat_A", 128'(mat_a1), 128'(0));
    check_output("areset_mat_B", 128'(mat_b1), 128'(0));
    check_output("areset_busy", 128'(busy1), 128'(0));
    check_output("areset_start", 128'(start1), 128'(0));
    #1;
    rst_n = 1'b1;
    apply_stimulus(0, 32'h0, 1, 0);
    #1;
    check_output("areset_ready_after", 128'(bus1.in_ready), 128'(1));
    apply_stimulus(0, 32'h0, 0, 0);
    #1;
    check_output("areset_late_done_busy", 128'(busy1), 128'(0));
    check_output("areset_late_done_start", 128'(start1), 128'(0));
    check_output("areset_late_done_ready", 128'(bus1.in_ready), 128'(1));
    check_output("areset_late_done_mat_A", 128'(mat_a1), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
